// File: rtl/dmem_responder.sv
// Data-memory responder: word storage with fixed-latency reads, returning
// {data, tag} in acceptance order through a credit-limited response queue.
module dmem_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_wdata,
    input  logic [TAG_W-1:0]      req_tag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [15:0]           rsp_rdata,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic                  idle
);
    localparam int WORDS  = 2 ** (ADDR_WIDTH - 1);
    localparam int STAGES = LATENCY - 1;
    localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    logic [ADDR_WIDTH-2:0] word_idx;
    logic                  unused_addr_lsb;
    logic                  accept;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [15:0]           rd_word;
    logic                  push_valid;
    logic [15:0]           push_data;
    logic [TAG_W-1:0]      push_tag;
    logic                  pop;
    logic [CW-1:0]         credit;
    logic [CW-1:0]         count;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         rd_ptr_inc;

    logic [15:0]      mem    [WORDS];
    logic [15:0]      q_data [FIFO_DEPTH];
    logic [TAG_W-1:0] q_tag  [FIFO_DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign word_idx        = req_addr[ADDR_WIDTH-1:1];
    assign unused_addr_lsb = req_addr[0];

    // Credit covers reads in the delay line plus queued responses, so the
    // handshake depends on registered state only.
    assign req_ready  = (credit < DEPTH_C);
    assign idle       = (credit == '0);
    assign rsp_valid  = (count != '0);
    assign accept     = req_valid & req_ready;
    assign wr_accept  = accept & req_wr;
    assign rd_accept  = accept & ~req_wr;
    assign pop        = rsp_valid & rsp_ready;
    assign rd_word    = mem[word_idx];
    assign rd_ptr_inc = ptr_inc(rd_ptr);

    // NOTE: storage arrays carry no reset; only control state is cleared.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[word_idx] <= req_wdata;
        end
    end

    generate
        if (STAGES == 0) begin : g_direct
            assign push_valid = rd_accept;
            assign push_data  = rd_word;
            assign push_tag   = req_tag;
        end else begin : g_delay
            logic [STAGES-1:0] dl_valid;
            logic [15:0]       dl_data [STAGES];
            logic [TAG_W-1:0]  dl_tag  [STAGES];

            // NOTE: sequential state always uses non-blocking assignments so
            // every stage samples its predecessor's pre-edge value.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dl_valid <= '0;
                end else begin
                    dl_valid[0] <= rd_accept;
                    for (int i = 1; i < STAGES; i++) begin
                        dl_valid[i] <= dl_valid[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                dl_data[0] <= rd_word;
                dl_tag[0]  <= req_tag;
                for (int i = 1; i < STAGES; i++) begin
                    dl_data[i] <= dl_data[i-1];
                    dl_tag[i]  <= dl_tag[i-1];
                end
            end

            assign push_valid = dl_valid[STAGES-1];
            assign push_data  = dl_data[STAGES-1];
            assign push_tag   = dl_tag[STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push_valid) begin
            q_data[wr_ptr] <= push_data;
            q_tag[wr_ptr]  <= push_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            credit <= '0;
        end else begin
            if (push_valid) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)        rd_ptr <= rd_ptr_inc;
            case ({push_valid, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            case ({rd_accept, pop})
                2'b10:   credit <= credit + 1'b1;
                2'b01:   credit <= credit - 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    // Head registers track the entry at rd_ptr and keep the last head once
    // the queue drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= '0;
            rsp_tag   <= '0;
        end else if (push_valid && (count == '0 || (pop && count == ONE_C))) begin
            rsp_rdata <= push_data;
            rsp_tag   <= push_tag;
        end else if (pop && count > ONE_C) begin
            rsp_rdata <= q_data[rd_ptr_inc];
            rsp_tag   <= q_tag[rd_ptr_inc];
        end
    end

endmodule
